// File: rtl/rv32i_pkg.sv
// Shared RV32I decode types: the mnemonic enum produced by the decoder and
// consumed by the execute-stage units (including rv32i_lsu).
package rv32i_pkg;

  typedef enum logic [5:0] {
    LUI, AUIPC, JAL, JALR,
    BEQ, BNE, BLT, BGE, BLTU, BGEU,
    LB, LH, LW, LBU, LHU,
    SB, SH, SW,
    ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
    ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
    FENCE, ECALL, EBREAK
  } RV32I_INSTRUCTION_MNEMONIC_t;

endpackage

// File: rtl/rv32i_lsu.sv
// RV32I load/store unit: IDLE/REQ/RESP handshake to a word bus with timeout.
// Optional alignment trap: define RV32I_LSU_MISALIGN_TRAP_EN.
module rv32i_lsu
  import rv32i_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req_valid,
  input  RV32I_INSTRUCTION_MNEMONIC_t mnemonic,
  input  logic [31:0]                 addr,
  input  logic [31:0]                 wdata,
  output logic                        req_ready,
  output logic                        stall,
  output logic                        rsp_valid,
  output logic [31:0]                 rd_data,
  output logic                        bus_err,
`ifdef RV32I_LSU_MISALIGN_TRAP_EN
  output logic                        misaligned,
`endif
  output logic                        mem_req,
  output logic                        mem_we,
  output logic [31:0]                 mem_addr,
  output logic [3:0]                  mem_be,
  output logic [31:0]                 mem_wdata,
  input  logic                        mem_ack,
  input  logic [31:0]                 mem_rdata
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]                  state;
  RV32I_INSTRUCTION_MNEMONIC_t mn_q;
  logic [31:0]                 addr_q;
  logic [31:0]                 wdata_q;
  logic [31:0]                 rd_q;
  logic [CW-1:0]               cnt;
  logic                        err_q;
  logic                        accept;
  logic                        in_req;
`ifdef RV32I_LSU_MISALIGN_TRAP_EN
  logic                        mis_q;
`endif

  function automatic logic is_mem(input RV32I_INSTRUCTION_MNEMONIC_t m);
    return m inside {LB, LH, LW, LBU, LHU, SB, SH, SW};
  endfunction

  function automatic logic is_store(input RV32I_INSTRUCTION_MNEMONIC_t m);
    return m inside {SB, SH, SW};
  endfunction

`ifdef RV32I_LSU_MISALIGN_TRAP_EN
  function automatic logic is_misaligned(input RV32I_INSTRUCTION_MNEMONIC_t m,
                                         input logic [1:0] a);
    case (m)
      LH, LHU, SH: return a[0];
      LW, SW:      return |a;
      default:     return 1'b0;
    endcase
  endfunction
`endif

  // Halfword lane uses addr[1] only and words ignore addr[1:0], so an
  // unaligned access without the trap silently rounds down.
  function automatic logic [31:0] load_extend(input RV32I_INSTRUCTION_MNEMONIC_t m,
                                              input logic [1:0] a,
                                              input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = a[1] ? w[31:16] : w[15:0];
    case (m)
      LB:      return {{24{b[7]}}, b};
      LBU:     return {24'h0, b};
      LH:      return {{16{h[15]}}, h};
      LHU:     return {16'h0, h};
      LW:      return w;
      default: return '0;
    endcase
  endfunction

  assign accept = (state == IDLE) && req_valid && is_mem(mnemonic);
  assign in_req = (state == REQ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      mn_q    <= RV32I_INSTRUCTION_MNEMONIC_t'('0);
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
      cnt     <= '0;
      err_q   <= 1'b0;
`ifdef RV32I_LSU_MISALIGN_TRAP_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            mn_q    <= mnemonic;
            addr_q  <= addr;
            wdata_q <= wdata;
            rd_q    <= '0;
            cnt     <= '0;
            err_q   <= 1'b0;
            state   <= REQ;
`ifdef RV32I_LSU_MISALIGN_TRAP_EN
            mis_q   <= is_misaligned(mnemonic, addr[1:0]);
            if (is_misaligned(mnemonic, addr[1:0])) state <= RESP;
`endif
          end
        end
        REQ: begin
          // Ack is checked first so it wins over a simultaneous expiry.
          if (mem_ack) begin
            rd_q  <= is_store(mn_q) ? '0 : load_extend(mn_q, addr_q[1:0], mem_rdata);
            state <= RESP;
          end else if (cnt == CNT_LAST) begin
            err_q <= 1'b1;
            rd_q  <= '0;
            state <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    req_ready = (state == IDLE);
    stall     = rst_n && (accept || in_req);
    rsp_valid = (state == RESP);
    rd_data   = rsp_valid ? rd_q : '0;
    bus_err   = rsp_valid && err_q;
`ifdef RV32I_LSU_MISALIGN_TRAP_EN
    misaligned = rsp_valid && mis_q;
`endif
    mem_req   = in_req;
    mem_we    = in_req && is_store(mn_q);
    mem_addr  = in_req ? {addr_q[31:2], 2'b00} : '0;
    mem_be    = '0;
    mem_wdata = '0;
    if (in_req) begin
      case (mn_q)
        SB: begin
          mem_be    = 4'b0001 << addr_q[1:0];
          mem_wdata = {4{wdata_q[7:0]}};
        end
        SH: begin
          mem_be    = addr_q[1] ? 4'b1100 : 4'b0011;
          mem_wdata = {2{wdata_q[15:0]}};
        end
        SW: begin
          mem_be    = 4'b1111;
          mem_wdata = wdata_q;
        end
        default: mem_be = 4'b1111;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_lsu.sv
// Scoreboard bench for rv32i_lsu: directed operations push expected responses,
// a negedge monitor pops and compares on every rsp_valid.
module tb_rv32i_lsu;
  import rv32i_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                        rst_n;
  logic                        req_valid;
  RV32I_INSTRUCTION_MNEMONIC_t mnemonic;
  logic [31:0]                 addr, wdata;
  logic                        req_ready, stall, rsp_valid, bus_err;
  logic [31:0]                 rd_data;
  logic                        mem_req, mem_we, mem_ack;
  logic [31:0]                 mem_addr, mem_wdata, mem_rdata;
  logic [3:0]                  mem_be;
`ifdef RV32I_LSU_MISALIGN_TRAP_EN
  logic                        misaligned;
`endif

  rv32i_lsu #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .mnemonic(mnemonic),
    .addr(addr), .wdata(wdata), .req_ready(req_ready), .stall(stall),
    .rsp_valid(rsp_valid), .rd_data(rd_data), .bus_err(bus_err),
`ifdef RV32I_LSU_MISALIGN_TRAP_EN
    .misaligned(misaligned),
`endif
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  typedef struct packed {
    logic [31:0] rd;
    logic        err;
    logic        mis;
  } rsp_t;

  rsp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp_valid", 32'(rsp_valid), 32'd0);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        chk("rd_data", rd_data, e.rd);
        chk("bus_err", 32'(bus_err), 32'(e.err));
`ifdef RV32I_LSU_MISALIGN_TRAP_EN
        chk("misaligned", 32'(misaligned), 32'(e.mis));
`endif
      end
    end
  end

  task automatic run_op(input RV32I_INSTRUCTION_MNEMONIC_t m, input logic [31:0] a,
                        input logic [31:0] wd, input int ack_at, input logic [31:0] rdat,
                        input int exp_req, input logic [31:0] e_addr, input logic [3:0] e_be,
                        input logic e_we, input logic [31:0] e_wdata, input rsp_t e);
    int reqcnt;
    bit done;
    @(posedge clk); #1;
    req_valid = 1'b1; mnemonic = m; addr = a; wdata = wd;
    exp_q.push_back(e);
    @(negedge clk);
    chk("ready_idle", 32'(req_ready), 32'd1);
    chk("stall_present", 32'(stall), 32'd1);
    @(posedge clk); #1;
    // Scramble inputs to prove they were registered at accept.
    req_valid = 1'b0; mnemonic = ADDI; addr = 32'hFFFF_FFFF; wdata = 32'h0;
    reqcnt = 0;
    done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      mem_ack   = (k == ack_at);
      mem_rdata = (k == ack_at) ? rdat : 32'hA5A5_A5A5;
      @(negedge clk);
      if (!mem_req) begin
        done = 1'b1;
        chk("rsp_after_req", 32'(rsp_valid), 32'd1);
        chk("req_cycles", 32'(reqcnt), 32'(exp_req));
      end else begin
        reqcnt++;
        if (k == 0) begin
          chk("mem_addr", mem_addr, e_addr);
          chk("mem_be", 32'(mem_be), 32'(e_be));
          chk("mem_we", 32'(mem_we), 32'(e_we));
          if (e_we) chk("mem_wdata", mem_wdata, e_wdata);
          chk("stall_req", 32'(stall), 32'd1);
          chk("ready_req", 32'(req_ready), 32'd0);
        end
        @(posedge clk); #1;
        mem_ack = 1'b0;
      end
    end
    mem_ack = 1'b0;
    if (!done) chk("rsp_timeout_bound", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; mnemonic = ADDI; addr = '0; wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    #12;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
`ifdef RV32I_LSU_MISALIGN_TRAP_EN
    chk("rst_misaligned", 32'(misaligned), 32'd0);
`endif
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_be", 32'(mem_be), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;

    // op, addr, wdata, ack_at, rdata, req_cycles, mem_addr, be, we, mem_wdata, {rd, err, mis}
    run_op(LB,  32'h103, 32'h0,         0, 32'h80FF_0000, 1,  32'h100, 4'b1111, 1'b0, 32'h0,         '{32'hFFFF_FF80, 1'b0, 1'b0});
    run_op(SH,  32'h202, 32'h1234_ABCD, 0, 32'h0,         1,  32'h200, 4'b1100, 1'b1, 32'hABCD_ABCD, '{32'h0, 1'b0, 1'b0});
    run_op(LHU, 32'h0,   32'h0,        -1, 32'h0,         16, 32'h0,   4'b1111, 1'b0, 32'h0,         '{32'h0, 1'b1, 1'b0});
`ifdef RV32I_LSU_MISALIGN_TRAP_EN
    run_op(LW,  32'h102, 32'h0,         0, 32'hDEAD_BEEF, 0,  32'h0,   4'b0000, 1'b0, 32'h0,         '{32'h0, 1'b0, 1'b1});
`else
    run_op(LW,  32'h102, 32'h0,         0, 32'hDEAD_BEEF, 1,  32'h100, 4'b1111, 1'b0, 32'h0,         '{32'hDEAD_BEEF, 1'b0, 1'b0});
`endif
    run_op(LH,  32'h102, 32'h0,         2, 32'h8001_1234, 3,  32'h100, 4'b1111, 1'b0, 32'h0,         '{32'hFFFF_8001, 1'b0, 1'b0});
    run_op(LBU, 32'h101, 32'h0,         0, 32'h0000_9A00, 1,  32'h100, 4'b1111, 1'b0, 32'h0,         '{32'h0000_009A, 1'b0, 1'b0});
    run_op(SB,  32'h3,   32'h0000_0055, 1, 32'h0,         2,  32'h0,   4'b1000, 1'b1, 32'h5555_5555, '{32'h0, 1'b0, 1'b0});
    run_op(SW,  32'h10,  32'hCAFE_F00D, 0, 32'h0,         1,  32'h10,  4'b1111, 1'b1, 32'hCAFE_F00D, '{32'h0, 1'b0, 1'b0});
    run_op(LW,  32'h20,  32'h0,        15, 32'h1234_5678, 16, 32'h20,  4'b1111, 1'b0, 32'h0,         '{32'h1234_5678, 1'b0, 1'b0});
    run_op(LHU, 32'h2,   32'h0,         0, 32'hF00D_1234, 1,  32'h0,   4'b1111, 1'b0, 32'h0,         '{32'h0000_F00D, 1'b0, 1'b0});

    // Non-memory mnemonic is ignored; a stray ack in IDLE produces nothing.
    @(posedge clk); #1;
    req_valid = 1'b1; mnemonic = ADDI; addr = 32'h40;
    @(negedge clk);
    chk("addi_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
    @(negedge clk);
    chk("addi_no_req", 32'(mem_req), 32'd0);
    chk("addi_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(negedge clk);
    chk("idle_ack_no_rsp", 32'(rsp_valid), 32'd0);

    // Asynchronous reset in the third REQ cycle of a load.
    @(posedge clk); #1;
    req_valid = 1'b1; mnemonic = LW; addr = 32'h40;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("req_before_reset", 32'(mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_drops_mem_req", 32'(mem_req), 32'd0);
    chk("reset_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_reset_ready", 32'(req_ready), 32'd1);
    chk("post_reset_no_req", 32'(mem_req), 32'd0);

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv32i_lsu.md
RV32I_LSU -- requirements
Module: rv32i_lsu

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, is the maximum number of REQ-state cycles to wait for mem_ack (minimum 1).
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 req_valid  input  1  execute stage presents an operation.
REQ-005 mnemonic  input  RV32I_INSTRUCTION_MNEMONIC_t  decoded instruction.
REQ-006 addr  input  32  effective address (ALU out).
REQ-007 wdata  input  32  store data (rs2).
REQ-008 req_ready  output  1  LSU can accept; high only in IDLE.
REQ-009 stall  output  1  hold the pipeline; high while a memory operation is accepted and has not yet reached RESP.
REQ-010 rsp_valid  output  1  one-cycle completion pulse.
REQ-011 rd_data  output  32  extended load result; 0 for stores and errors.
REQ-012 bus_err  output  1  timeout flag, valid with rsp_valid.
REQ-013 misaligned  output  1  misalignment flag, valid with rsp_valid (present only under RV32I_LSU_MISALIGN_TRAP_EN).
REQ-014 mem_req/mem_we  output  1/1  bus request and write enable.
REQ-015 mem_addr  output  32  word-aligned address, {addr[31:2],2'b00}.
REQ-016 mem_be/mem_wdata  output  4/32  byte enables and lane-replicated store data.
REQ-017 mem_ack/mem_rdata  input  1/32  bus acknowledge and read word.

Function
REQ-018 Memory mnemonics are LB, LH, LW, LBU, LHU, SB, SH and SW; a req_valid with any other mnemonic is ignored and no transaction starts.
REQ-019 FSM states are IDLE, REQ and RESP.
REQ-020 IDLE->REQ occurs on req_valid with a memory mnemonic; mnemonic, addr and wdata are registered on the same edge, and later input changes are ignored.
REQ-021 In REQ, mem_req is held with stable outputs until mem_ack; on mem_ack, mem_rdata is captured and the FSM moves to RESP.
REQ-022 RESP asserts rsp_valid for exactly one cycle, then returns to IDLE; a new accept is possible on the following cycle.
REQ-023 Minimum latency is 2 cycles from accept edge to rsp_valid (mem_ack in the first REQ cycle).
REQ-024 stall = (IDLE and a memory request is presented) or REQ.
REQ-025 Byte enables: SB 4'b0001<<addr[1:0]; SH 4'b0011<<{addr[1],1'b0}; SW 4'b1111.
REQ-026 Store data: SB replicates wdata[7:0] on all lanes; SH replicates wdata[15:0]; SW passes wdata unchanged.
REQ-027 Load data: the byte or half is selected by addr[1:0]; LB and LH sign-extend, LBU and LHU zero-extend, LW passes the word.
REQ-028 Loads drive mem_we=0 and mem_be=4'b1111.
REQ-029 A timeout counter clears on REQ entry and increments each REQ cycle without mem_ack; after TIMEOUT_CYCLES cycles, mem_req drops, the FSM enters RESP, bus_err=1 and rd_data=0.
REQ-030 A mem_ack in the same cycle as the timeout expiry wins: normal completion and bus_err=0.
REQ-031 mem_ack outside REQ is ignored.

Reset
REQ-032 rst_n low immediately forces IDLE and clears the counter and captured registers, including mid-transaction; mem_req drops without waiting for a clock.
REQ-033 Reset values: req_ready=1, stall=0, rsp_valid=0, rd_data=0, bus_err=0, misaligned=0, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0.

Configuration
REQ-034 With RV32I_LSU_MISALIGN_TRAP_EN defined: LH, LHU or SH with addr[0]=1, and LW or SW with addr[1:0]!=0, issue no bus request, go IDLE->RESP, and complete with misaligned=1 and rd_data=0.
REQ-035 Without RV32I_LSU_MISALIGN_TRAP_EN: the misaligned port is absent; for halfwords addr[0] is treated as 0 and for words addr[1:0] is treated as 0, and the access proceeds normally.

Verification
REQ-036 LB addr=0x103, mem_rdata=0x80FF_0000, ack in 1st REQ cycle -> mem_be=4'b1111, rd_data=0xFFFF_FF80, rsp_valid 2 cycles after accept.
REQ-037 SH addr=0x202, wdata=0x1234_ABCD -> mem_addr=0x200, mem_be=4'b1100, mem_wdata=0xABCD_ABCD, mem_we=1, rd_data=0.
REQ-038 LHU addr=0x0, mem_ack withheld, TIMEOUT_CYCLES=16 -> mem_req for exactly 16 cycles, then rsp_valid with bus_err=1 and rd_data=0.
REQ-039 LW accepted, rst_n pulled low in the 3rd REQ cycle -> mem_req low with no clock edge; after release req_ready=1 and no rsp_valid.
REQ-040 LW addr=0x102: with the macro -> no mem_req, next-cycle rsp_valid with misaligned=1; without the macro -> mem_addr=0x100 and a normal load.
REQ-041 ADDI with req_valid=1 -> no state change, stall=0; mem_ack pulse in IDLE -> no rsp_valid.
